// File: rtl/audio_pkg.sv
// Shared types and constants for the audio UART return path.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_FRAME_BITS = 10;

    // Line time of one 16-bit sample: two 8N1 frames.
    function automatic int clks_per_sample(input int clks_per_bit);
        return 2 * UART_FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous sample FIFO; push-when-full and pop-when-empty are ignored.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_25mhz,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  sample_t                  din,
    output sample_t                  dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sample_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/audio_uart_tx.sv
// Buffers processed PCM samples and sends each as two 8N1 bytes, low byte first.
module audio_uart_tx
    import audio_pkg::*;
#(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic    clk_25mhz,
    input  logic    rst,
    input  sample_t sample_in,
    input  logic    sample_valid,
    output logic    tx,
    output logic    busy,
    output logic    fifo_full,
    output logic    overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t    state;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic           byte_sel;
    sample_t        holder;

    sample_t        fifo_dout;
    logic           fifo_empty;
    logic           fifo_is_full;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  count_next;
    logic           push_ok;
    logic           pop;
    logic           bit_done;
    logic [7:0]     cur_byte;

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .push      (sample_valid),
        .pop       (pop),
        .din       (sample_in),
        .dout      (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_is_full),
        .count     (fifo_count)
    );

    assign push_ok    = sample_valid && !fifo_is_full;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign count_next = fifo_count + CW'(push_ok) - CW'(pop);
    assign bit_done   = (baud_cnt == BAUD_LAST);
    assign cur_byte   = byte_sel ? holder[15:8] : holder[7:0];

    // tx is driven from the current state, so the line trails the FSM by one
    // cycle; this puts the start bit two edges after a push into an idle block.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_sel  <= 1'b0;
            holder    <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow  <= sample_valid && fifo_is_full;
            fifo_full <= (count_next == CW'(FIFO_DEPTH));
            busy      <= (state != IDLE) || (fifo_count != '0);

            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        holder   <= fifo_dout;
                        byte_sel <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= cur_byte[bit_idx];
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_uart_tx.sv
// Directed and randomized bench for audio_uart_tx with a line decoder and an occupancy model.
module tb_audio_uart_tx;

    localparam int CPB     = 8;
    localparam int DEF_CPB = 25_000_000 / 115_200;
    localparam int DEPTH   = 4;

    logic        clk_25mhz = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_def = '0;
    logic        valid_def = 1'b0;
    logic        tx, busy, fifo_full, overflow;
    logic        tx_def, busy_def, full_def, ovf_def;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit check_on = 1'b0;

    // Reference model: occupancy count, transmitter free time, expected frames.
    int          m_cnt = 0;
    int          m_next_free = 0;
    bit          m_full = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_acc, m_pop;
    logic [15:0] m_q[$];
    logic [15:0] exp_val[$];
    int          exp_start[$];

    logic [7:0]  rx_bytes[$];
    int          rx_starts[$];
    logic [7:0]  mon_data;
    int          mon_start, mon_status;

    logic [15:0] stim [8];
    logic        full_log [9];
    logic        ovf_log [9];
    int          cnt_log [9];

    always #20 clk_25mhz = ~clk_25mhz;

    audio_uart_tx #(
        .CLK_FREQ   (800_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_25mhz    (clk_25mhz),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .tx           (tx),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    audio_uart_tx dut_def (
        .clk_25mhz    (clk_25mhz),
        .rst          (rst),
        .sample_in    (sample_def),
        .sample_valid (valid_def),
        .tx           (tx_def),
        .busy         (busy_def),
        .fifo_full    (full_def),
        .overflow     (ovf_def)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // A sample leaving the FIFO appears on the line one cycle later; the next
    // pop is possible one cycle after both frames have finished.
    initial forever begin
        @(posedge clk_25mhz);
        cyc++;
        if (rst) begin
            m_cnt = 0;
            m_next_free = 0;
            m_full = 1'b0;
            m_ovf = 1'b0;
            m_q.delete();
        end else begin
            m_acc = sample_valid && (m_cnt < DEPTH);
            m_pop = (m_cnt > 0) && (cyc >= m_next_free);
            m_ovf = sample_valid && !m_acc;
            if (m_pop) begin
                exp_val.push_back(m_q.pop_front());
                exp_start.push_back(cyc + 1);
                m_next_free = cyc + audio_pkg::clks_per_sample(CPB) + 1;
            end
            if (m_acc) m_q.push_back(sample_in);
            m_cnt = m_cnt + int'(m_acc) - int'(m_pop);
            m_full = (m_cnt == DEPTH);
        end
    end

    initial forever begin
        @(negedge clk_25mhz);
        if (check_on && !rst) begin
            checkOutput("fifo_full", fifo_full, m_full);
            checkOutput("overflow", overflow, m_ovf);
            checkOutput("fifo_count", dut.u_fifo.count, m_cnt);
        end
    end

    // Decodes one 8N1 frame, requiring every bit to hold for exactly cpb cycles.
    // status: 0 ok, 1 no start bit seen, 2 aborted by reset, 3 framing error.
    task automatic captureFrame(input bit use_def, input int cpb, input int max_wait,
                                output logic [7:0] data, output int start_cyc, output int status);
        logic [9:0] bits;
        logic       cur;
        int         waited;
        status = 0;
        waited = 0;
        data = '0;
        start_cyc = 0;
        bits = '0;
        do begin
            @(negedge clk_25mhz);
            waited++;
            cur = use_def ? tx_def : tx;
        end while (cur !== 1'b0 && waited < max_wait);
        if (cur !== 1'b0) begin
            status = 1;
            return;
        end
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < cpb; c++) begin
                if (i != 0 || c != 0) begin
                    @(negedge clk_25mhz);
                    cur = use_def ? tx_def : tx;
                end
                if (rst) begin
                    status = 2;
                    return;
                end
                if (c == 0) bits[i] = cur;
                else if (cur !== bits[i]) status = 3;
            end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) status = 3;
        data = bits[8:1];
    endtask

    initial forever begin
        captureFrame(1'b0, CPB, 1000, mon_data, mon_start, mon_status);
        if (mon_status == 0 || mon_status == 3) begin
            checkOutput("frame_shape", mon_status, 0);
            if (mon_status == 0) begin
                rx_bytes.push_back(mon_data);
                rx_starts.push_back(mon_start);
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] vals [8], input int n, output int first_edge);
        first_edge = 0;
        @(negedge clk_25mhz);
        sample_in = vals[0];
        sample_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_25mhz);
            if (i == 0) first_edge = cyc;
            full_log[i] = fifo_full;
            ovf_log[i] = overflow;
            cnt_log[i] = int'(dut.u_fifo.count);
            if (i + 1 < n) sample_in = vals[i + 1];
            else sample_valid = 1'b0;
        end
        @(negedge clk_25mhz);
        full_log[n] = fifo_full;
        ovf_log[n] = overflow;
        cnt_log[n] = int'(dut.u_fifo.count);
    endtask

    task automatic waitBusy(input bit use_def, input bit level, input int max_cycles,
                            input string tag, output int at_cyc);
        logic cur;
        int   n;
        n = 0;
        do begin
            @(negedge clk_25mhz);
            n++;
            cur = use_def ? busy_def : busy;
        end while (cur !== level && n < max_cycles);
        at_cyc = cyc;
        checkOutput(tag, cur, level);
    endtask

    task automatic clearQueues();
        exp_val.delete();
        exp_start.delete();
        rx_bytes.delete();
        rx_starts.delete();
    endtask

    task automatic checkFrames(input string tag);
        checkOutput({tag, "_nbytes"}, rx_bytes.size(), 2 * exp_val.size());
        for (int i = 0; i < exp_val.size() && 2 * i + 1 < rx_bytes.size(); i++) begin
            checkOutput({tag, "_sample"}, {rx_bytes[2*i+1], rx_bytes[2*i]}, exp_val[i]);
            checkOutput({tag, "_start_lo"}, rx_starts[2*i], exp_start[i]);
            checkOutput({tag, "_start_hi"}, rx_starts[2*i+1], exp_start[i] + 10 * CPB);
        end
        clearQueues();
    endtask

    initial begin
        int          e, t_idle, s0, s1, st0, st1, target, burst;
        logic [7:0]  d0, d1;

        rst = 1'b1;
        repeat (5) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_full", fifo_full, 1'b0);
        checkOutput("rst_ovf", overflow, 1'b0);
        checkOutput("rst_tx_def", tx_def, 1'b1);
        checkOutput("rst_busy_def", busy_def, 1'b0);
        checkOutput("rst_full_def", full_def, 1'b0);
        checkOutput("rst_ovf_def", ovf_def, 1'b0);
        rst = 1'b0;
        check_on = 1'b1;
        repeat (100) begin
            @(negedge clk_25mhz);
            checkOutput("idle_tx", tx, 1'b1);
        end

        $display("[TB] single sample 0x1234");
        clearQueues();
        stim[0] = 16'h1234;
        applyStimulus(stim, 1, e);
        waitBusy(1'b0, 1'b1, 10, "single_busy_hi", t_idle);
        waitBusy(1'b0, 1'b0, 400, "single_busy_lo", t_idle);
        d0 = 'x; d1 = 'x; s0 = -1; s1 = -1;
        if (rx_bytes.size() >= 2) begin
            d0 = rx_bytes[0]; d1 = rx_bytes[1];
            s0 = rx_starts[0]; s1 = rx_starts[1];
        end
        checkOutput("single_nbytes", rx_bytes.size(), 2);
        checkOutput("single_lo", d0, 8'h34);
        checkOutput("single_hi", d1, 8'h12);
        checkOutput("single_latency", s0, e + 2);
        checkOutput("single_hi_start", s1, e + 2 + 80);
        checkOutput("single_busy_drop", t_idle, e + 2 + 160);
        checkFrames("single");

        $display("[TB] default baud, sample -10000");
        @(negedge clk_25mhz);
        sample_def = -16'sd10000;
        valid_def = 1'b1;
        @(negedge clk_25mhz);
        valid_def = 1'b0;
        e = cyc;
        captureFrame(1'b1, DEF_CPB, 50, d0, s0, st0);
        captureFrame(1'b1, DEF_CPB, 50, d1, s1, st1);
        waitBusy(1'b1, 1'b0, 500, "def_busy_lo", t_idle);
        checkOutput("def_status_lo", st0, 0);
        checkOutput("def_status_hi", st1, 0);
        checkOutput("def_lo", d0, 8'hF0);
        checkOutput("def_hi", d1, 8'hD8);
        checkOutput("def_latency", s0, e + 2);
        checkOutput("def_hi_start", s1, s0 + 10 * 217);
        checkOutput("def_total", t_idle - s0, 4340);

        $display("[TB] overflow burst 1..6");
        clearQueues();
        for (int i = 0; i < 6; i++) stim[i] = 16'(i + 1);
        applyStimulus(stim, 6, e);
        checkOutput("ovf_full_after4", full_log[3], 1'b0);
        checkOutput("ovf_full_after5", full_log[4], 1'b1);
        checkOutput("ovf_pulse_before", ovf_log[4], 1'b0);
        checkOutput("ovf_pulse", ovf_log[5], 1'b1);
        checkOutput("ovf_pulse_end", ovf_log[6], 1'b0);
        waitBusy(1'b0, 1'b0, 2000, "ovf_busy_lo", t_idle);
        checkOutput("ovf_nsamples", exp_val.size(), 5);
        checkOutput("ovf_gap", (rx_starts.size() >= 3) ? rx_starts[2] - rx_starts[0] : -1, 20 * CPB + 1);
        checkFrames("ovf");

        $display("[TB] push on the pop edge");
        stim[0] = 16'hAAAA;
        stim[1] = 16'h5555;
        applyStimulus(stim, 2, e);
        checkOutput("pushpop_cnt0", cnt_log[0], 1);
        checkOutput("pushpop_cnt1", cnt_log[1], 1);
        waitBusy(1'b0, 1'b0, 1000, "pushpop_busy_lo", t_idle);
        checkFrames("pushpop");

        $display("[TB] reset during high-byte data bit 3");
        stim[0] = 16'hABCD;
        stim[1] = 16'h1111;
        stim[2] = 16'h2222;
        applyStimulus(stim, 3, e);
        target = e + 2 + 14 * CPB + 3;
        while (cyc < target) @(negedge clk_25mhz);
        rst = 1'b1;
        #1;
        checkOutput("midrst_tx", tx, 1'b1);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_full", fifo_full, 1'b0);
        checkOutput("midrst_ovf", overflow, 1'b0);
        repeat (3) @(negedge clk_25mhz);
        rst = 1'b0;
        clearQueues();
        repeat (50) begin
            @(negedge clk_25mhz);
            checkOutput("midrst_no_resume", tx, 1'b1);
        end
        checkOutput("midrst_fifo_empty", dut.u_fifo.count, 0);
        stim[0] = 16'h00FF;
        applyStimulus(stim, 1, e);
        waitBusy(1'b0, 1'b0, 400, "midrst_busy_lo", t_idle);
        checkOutput("midrst_nbytes", rx_bytes.size(), 2);
        checkOutput("midrst_lo", (rx_bytes.size() >= 1) ? rx_bytes[0] : 8'hxx, 8'hFF);
        checkOutput("midrst_hi", (rx_bytes.size() >= 2) ? rx_bytes[1] : 8'hxx, 8'h00);
        checkFrames("midrst");

        $display("[TB] randomized bursts");
        repeat (40) begin
            repeat ($urandom_range(0, 200)) @(negedge clk_25mhz);
            burst = $urandom_range(1, 6);
            for (int i = 0; i < burst; i++) stim[i] = 16'($urandom);
            applyStimulus(stim, burst, e);
        end
        waitBusy(1'b0, 1'b0, 20000, "rand_busy_lo", t_idle);
        repeat (4) @(negedge clk_25mhz);
        checkFrames("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
